// File: rtl/plic_pending_arbiter.sv
// Pending/claim arbiter for a single hart context.
// Latches gateway requests into pending bits, selects the highest-priority
// pending source (lowest ID on ties), drives the context irq, and serves
// claim/complete requests, pulsing gw_complete back to the gateways.
module plic_pending_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    localparam int ID_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        gw_valid,
    output logic [NUM_SRC-1:0]        gw_ready,
    output logic [NUM_SRC-1:0]        gw_complete,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    output logic                      irq,
    input  logic                      claim_valid,
    output logic                      claim_rsp_valid,
    output logic [ID_W-1:0]           claim_id,
    input  logic                      complete_valid,
    input  logic [ID_W-1:0]           complete_id
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic [ID_W-1:0]    best_id;
    logic [PRIO_W-1:0]  best_prio;

    // A source can only be re-requested once it is neither pending nor in service.
    assign gw_ready = ~pending & ~in_service;
    assign accept   = gw_valid & gw_ready;

    // Pick the pending source with the highest non-zero priority; the strict
    // compare on an ascending scan lets the lowest ID win ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && (src_prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = src_prio[i*PRIO_W +: PRIO_W];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    // One-hot decode of the claimed source and of a legal completion; an ID of
    // 0, out of range, or not in service matches no bit and is ignored.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_hit[i]    = claim_valid && (best_id == ID_W'(i + 1));
            complete_hit[i] = complete_valid && (complete_id == ID_W'(i + 1)) && in_service[i];
        end
    end

    // State update: accept/claim move sources pending -> in service, completes
    // release them. The masks touch disjoint bits, so ordering is irrelevant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending         <= '0;
            in_service      <= '0;
            gw_complete     <= '0;
            irq             <= 1'b0;
            claim_rsp_valid <= 1'b0;
            claim_id        <= '0;
        end else begin
            pending         <= (pending | accept) & ~claim_hit;
            in_service      <= (in_service | claim_hit) & ~complete_hit;
            gw_complete     <= complete_hit;
            irq             <= (best_prio > threshold);
            claim_rsp_valid <= claim_valid;
            if (claim_valid) begin
                claim_id <= best_id;
            end
        end
    end

endmodule

// File: tb/tb_plic_pending_arbiter.sv
// Directed bench for plic_pending_arbiter with hand-computed expectations.
module tb_plic_pending_arbiter;

    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 4;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_SRC-1:0]        gw_valid;
    logic [NUM_SRC-1:0]        gw_ready;
    logic [NUM_SRC-1:0]        gw_complete;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         threshold;
    logic                      irq;
    logic                      claim_valid;
    logic                      claim_rsp_valid;
    logic [ID_W-1:0]           claim_id;
    logic                      complete_valid;
    logic [ID_W-1:0]           complete_id;

    int checks = 0;
    int errors = 0;

    plic_pending_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .gw_valid        (gw_valid),
        .gw_ready        (gw_ready),
        .gw_complete     (gw_complete),
        .src_prio        (src_prio),
        .threshold       (threshold),
        .irq             (irq),
        .claim_valid     (claim_valid),
        .claim_rsp_valid (claim_rsp_valid),
        .claim_id        (claim_id),
        .complete_valid  (complete_valid),
        .complete_id     (complete_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_prio(input int src, input logic [PRIO_W-1:0] p);
        src_prio[(src-1)*PRIO_W +: PRIO_W] = p;
    endtask

    initial begin
        reset          = 1'b0;
        gw_valid       = '1;
        src_prio       = '0;
        threshold      = '0;
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        complete_id    = '0;

        // Reset held with all gateways requesting.
        repeat (3) step();
        check("rst_irq", irq, 0);
        check("rst_ready", gw_ready, 8'hFF);
        check("rst_rsp", claim_rsp_valid, 0);
        check("rst_cmpl", gw_complete, 8'h00);
        check("rst_id", claim_id, 0);
        reset    = 1'b1;
        gw_valid = '0;
        step();
        check("rel_ready", gw_ready, 8'hFF);
        check("rel_irq", irq, 0);

        // Single source 3.
        set_prio(3, 3'd2);
        threshold = 3'd0;
        gw_valid  = 8'h04;
        step();
        gw_valid = '0;
        check("s3_ready", gw_ready, 8'hFB);
        check("s3_irq_early", irq, 0);
        step();
        check("s3_irq", irq, 1);
        claim_valid = 1'b1;
        step();
        claim_valid = 1'b0;
        check("s3_rsp", claim_rsp_valid, 1);
        check("s3_id", claim_id, 3);
        step();
        check("s3_rsp_drop", claim_rsp_valid, 0);
        check("s3_id_hold", claim_id, 3);
        check("s3_irq_off", irq, 0);
        check("s3_ready_svc", gw_ready, 8'hFB);
        complete_valid = 1'b1;
        complete_id    = 4'd3;
        step();
        complete_valid = 1'b0;
        check("s3_cmpl", gw_complete, 8'h04);
        step();
        check("s3_cmpl_drop", gw_complete, 8'h00);
        check("s3_ready_back", gw_ready, 8'hFF);

        // Priority order and lowest-ID tie break: expect 7, 2, 5, 0.
        set_prio(2, 3'd5);
        set_prio(5, 3'd5);
        set_prio(7, 3'd6);
        gw_valid = 8'h52;
        step();
        gw_valid    = '0;
        claim_valid = 1'b1;
        step();
        check("pr_id0", claim_id, 7);
        step();
        check("pr_id1", claim_id, 2);
        step();
        check("pr_id2", claim_id, 5);
        step();
        claim_valid = 1'b0;
        check("pr_id3", claim_id, 0);
        check("pr_rsp3", claim_rsp_valid, 1);
        check("pr_ready", gw_ready, 8'hAD);

        // Illegal completes: id 0, id NUM_SRC+1, id not in service.
        complete_valid = 1'b1;
        complete_id    = 4'd0;
        step();
        check("ill0_cmpl", gw_complete, 8'h00);
        check("ill0_ready", gw_ready, 8'hAD);
        complete_id = 4'd9;
        step();
        check("ill9_cmpl", gw_complete, 8'h00);
        check("ill9_ready", gw_ready, 8'hAD);
        complete_id = 4'd1;
        step();
        check("ill1_cmpl", gw_complete, 8'h00);
        check("ill1_ready", gw_ready, 8'hAD);
        complete_id = 4'd2;
        step();
        complete_valid = 1'b0;
        check("ok2_cmpl", gw_complete, 8'h02);
        check("ok2_ready", gw_ready, 8'hAF);

        // Threshold: prio equal to threshold does not raise irq but is claimable.
        threshold = 3'd3;
        set_prio(1, 3'd3);
        gw_valid  = 8'h01;
        step();
        gw_valid = '0;
        step();
        check("thr_eq_irq", irq, 0);
        claim_valid = 1'b1;
        step();
        claim_valid = 1'b0;
        check("thr_claim", claim_id, 1);
        set_prio(4, 3'd3);
        threshold = 3'd2;
        gw_valid  = 8'h08;
        step();
        gw_valid = '0;
        step();
        check("thr_gt_irq", irq, 1);

        // Claim (src 4) and complete (src 5) in the same cycle.
        claim_valid    = 1'b1;
        complete_valid = 1'b1;
        complete_id    = 4'd5;
        step();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        check("cc_rsp", claim_rsp_valid, 1);
        check("cc_id", claim_id, 4);
        check("cc_cmpl", gw_complete, 8'h10);
        check("cc_ready", gw_ready, 8'hB6);

        // Accept and claim on the same edge: claim sees nothing yet.
        gw_valid    = 8'h04;
        claim_valid = 1'b1;
        step();
        gw_valid = '0;
        check("ac_id_none", claim_id, 0);
        step();
        claim_valid = 1'b0;
        check("ac_id_next", claim_id, 3);
        check("ac_ready", gw_ready, 8'hB2);

        // Reset arriving with a claim and a complete in flight.
        set_prio(6, 3'd1);
        gw_valid = 8'h20;
        step();
        gw_valid       = '0;
        claim_valid    = 1'b1;
        complete_valid = 1'b1;
        complete_id    = 4'd7;
        reset          = 1'b0;
        step();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        check("mr_rsp", claim_rsp_valid, 0);
        check("mr_cmpl", gw_complete, 8'h00);
        check("mr_id", claim_id, 0);
        check("mr_ready", gw_ready, 8'hFF);
        check("mr_irq", irq, 0);
        reset = 1'b1;
        step();
        check("mr_post_ready", gw_ready, 8'hFF);
        check("mr_post_irq", irq, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
